// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave with independent read/write FSMs and programmable response latency.
// Backing store is an internal word array indexed by address bits [MEM_AW+1:2]; addresses alias modulo its size.
module axil_mem_slave #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          LAT_MODE  = 0,
    parameter int          FIX_LAT   = 0,
    parameter logic [7:0]  LAT_MASK  = 8'h1f,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MEM_AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int         NWORDS     = DATA_W / 32;
    localparam int         ALIGN_BITS = $clog2(DATA_W / 8);
    localparam logic [7:0] FIX_DELAY  = 8'(FIX_LAT);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [2**MEM_AW];

    logic [15:0] lfsr;
    logic [7:0]  rd_delay;
    logic [7:0]  wr_delay;

    logic [1:0]        rstate;
    logic [7:0]        rcnt;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] mem_rd_word;
    logic [DATA_W-1:0] rd_word_sel;
    logic [1:0]        rd_resp_sel;
    logic              ar_misal;
    logic [MEM_AW-1:0] ar_idx;

    logic [1:0]          wstate;
    logic [7:0]          wcnt;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_hs;
    logic                w_hs;
    logic                wr_both;
    logic                wr_go;
    logic [ADDR_W-1:0]   wa;
    logic [DATA_W-1:0]   wd;
    logic [DATA_W/8-1:0] ws;
    logic                wr_misal;
    logic [MEM_AW-1:0]   wr_idx;

    logic unused_addr_bits;

    // Galois LFSR runs freely; each path samples its own byte when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (lfsr[0])
            lfsr <= (lfsr >> 1) ^ 16'hB400;
        else
            lfsr <= lfsr >> 1;
    end

    assign rd_delay = (LAT_MODE == 1) ? (lfsr[7:0]  & LAT_MASK) : FIX_DELAY;
    assign wr_delay = (LAT_MODE == 1) ? (lfsr[15:8] & LAT_MASK) : FIX_DELAY;

    assign ar_idx   = araddr[MEM_AW+1:2];
    assign ar_misal = |araddr[ALIGN_BITS-1:0];

    always_comb begin
        mem_rd_word = '0;
        for (int h = 0; h < NWORDS; h++)
            mem_rd_word[h*32 +: 32] = mem[ar_idx + MEM_AW'(h)];
    end

    assign rd_word_sel = ar_misal ? '0 : mem_rd_word;
    assign rd_resp_sel = ar_misal ? RESP_SLVERR : RESP_OKAY;
    assign arready     = (rstate == R_IDLE);

    // Memory is sampled at acceptance; a zero delay skips R_WAIT so rvalid follows the handshake directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_IDLE;
            rcnt    <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata_q <= rd_word_sel;
                        rresp_q <= rd_resp_sel;
                        if (rd_delay == 8'd0) begin
                            rstate <= R_RESP;
                            rvalid <= 1'b1;
                            rdata  <= rd_word_sel;
                            rresp  <= rd_resp_sel;
                        end else begin
                            rstate <= R_WAIT;
                            rcnt   <= rd_delay - 8'd1;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt == 8'd0) begin
                        rstate <= R_RESP;
                        rvalid <= 1'b1;
                        rdata  <= rdata_q;
                        rresp  <= rresp_q;
                    end else begin
                        rcnt <= rcnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rstate <= R_IDLE;
                        rvalid <= 1'b0;
                        rdata  <= '0;
                        rresp  <= RESP_OKAY;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign awready = (wstate == W_IDLE) && !aw_held;
    assign wready  = (wstate == W_IDLE) && !w_held;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign wr_both = (aw_held || aw_hs) && (w_held || w_hs);

    // Selects what the memory write port sees: live channel data while idle, latched data while waiting.
    always_comb begin
        wr_go = 1'b0;
        wa    = awaddr_q;
        wd    = wdata_q;
        ws    = wstrb_q;
        case (wstate)
            W_IDLE: begin
                wa    = aw_held ? awaddr_q : awaddr;
                wd    = w_held  ? wdata_q  : wdata;
                ws    = w_held  ? wstrb_q  : wstrb;
                wr_go = wr_both && (wr_delay == 8'd0);
            end
            W_WAIT:  wr_go = (wcnt == 8'd0);
            default: wr_go = 1'b0;
        endcase
    end

    assign wr_idx   = wa[MEM_AW+1:2];
    assign wr_misal = |wa[ALIGN_BITS-1:0];

    // A reset on the firing edge suppresses the write, so an interrupted transaction never lands.
    always_ff @(posedge clk) begin
        if (!rst && wr_go && !wr_misal) begin
            for (int h = 0; h < NWORDS; h++)
                for (int b = 0; b < 4; b++)
                    if (ws[h*4 + b])
                        mem[wr_idx + MEM_AW'(h)][b*8 +: 8] <= wd[h*32 + b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate   <= W_IDLE;
            wcnt     <= '0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= awaddr;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (wr_both) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        awaddr_q <= wa;
                        wdata_q  <= wd;
                        wstrb_q  <= ws;
                        if (wr_delay == 8'd0) begin
                            wstate <= W_RESP;
                            bvalid <= 1'b1;
                            bresp  <= wr_misal ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            wstate <= W_WAIT;
                            wcnt   <= wr_delay - 8'd1;
                        end
                    end
                end
                W_WAIT: begin
                    if (wcnt == 8'd0) begin
                        wstate <= W_RESP;
                        bvalid <= 1'b1;
                        bresp  <= wr_misal ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wcnt <= wcnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate <= W_IDLE;
                        bvalid <= 1'b0;
                        bresp  <= RESP_OKAY;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign unused_addr_bits = ^{araddr[ADDR_W-1:MEM_AW+2], wa[ADDR_W-1:MEM_AW+2]};

endmodule
